sort_input_loader: RTL and testbench

Front-end buffer for the 9-entry sort engine. Collects DEPTH operands from a valid/ready input stream into a local register buffer and issues a one-cycle start pulse to the sort control path. While the sort runs, it gives the sort datapath exclusive read/write access to the buffer. When the sort reports completion, it streams the buffer out on a valid/ready output port in address order.

---
 rtl/sort_input_loader.sv | 135 +++++++++++++
 tb/tb_sort_input_loader.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sort_input_loader.sv
// Operand buffer in front of the sort engine: fills from a valid/ready stream, lends the
// buffer to the sort datapath while it runs, then drains the result in address order.
module sort_input_loader #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 9,
    parameter int unsigned ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] in_data_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic              flush_i,
    output logic              start_o,
    input  logic              sort_done_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    output logic [DATA_W-1:0] rd_data_o,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [DATA_W-1:0] wr_data_i,
    output logic [DATA_W-1:0] out_data_o,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [ADDR_W-1:0] count_o,
    output logic              busy_o
);

    typedef enum logic [1:0] {StFill, StLaunch, StSort, StDrain} state_e;

    localparam logic [ADDR_W-1:0] DepthW  = ADDR_W'(DEPTH);
    localparam logic [ADDR_W-1:0] LastIdx = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] OneW    = ADDR_W'(1);

    state_e            r_state, w_state_d;
    logic [ADDR_W-1:0] r_count, w_count_d;
    logic [ADDR_W-1:0] r_ptr, w_ptr_d;
    logic [DATA_W-1:0] r_buf [DEPTH];

    logic              w_buf_we;
    logic [ADDR_W-1:0] w_buf_waddr;
    logic [DATA_W-1:0] w_buf_wdata;

    always_comb begin
        w_state_d   = r_state;
        w_count_d   = r_count;
        w_ptr_d     = r_ptr;
        in_ready_o  = 1'b0;
        start_o     = 1'b0;
        out_valid_o = 1'b0;
        out_data_o  = '0;
        count_o     = DepthW;
        busy_o      = 1'b1;
        w_buf_we    = 1'b0;
        w_buf_waddr = r_count;
        w_buf_wdata = in_data_i;

        unique case (r_state)
            StFill: begin
                busy_o     = 1'b0;
                count_o    = r_count;
                in_ready_o = !flush_i;
                if (in_valid_i && !flush_i) begin
                    w_buf_we = 1'b1;
                    if (r_count == LastIdx) begin
                        w_state_d = StLaunch;
                        w_count_d = '0;
                    end else begin
                        w_count_d = r_count + OneW;
                    end
                end
            end
            StLaunch: begin
                // sort_done_i may still be high from the previous job, so it is not looked at here
                start_o   = !flush_i;
                w_state_d = StSort;
            end
            StSort: begin
                if (wr_en_i && (wr_addr_i < DepthW)) begin
                    w_buf_we    = 1'b1;
                    w_buf_waddr = wr_addr_i;
                    w_buf_wdata = wr_data_i;
                end
                if (sort_done_i) begin
                    w_state_d = StDrain;
                    w_ptr_d   = '0;
                end
            end
            StDrain: begin
                out_valid_o = 1'b1;
                out_data_o  = r_buf[r_ptr];
                count_o     = DepthW - r_ptr;
                if (out_ready_i) begin
                    if (r_ptr == LastIdx) begin
                        w_state_d = StFill;
                        w_ptr_d   = '0;
                        w_count_d = '0;
                    end else begin
                        w_ptr_d = r_ptr + OneW;
                    end
                end
            end
            default: w_state_d = StFill;
        endcase

        // Abort overrides everything; the buffer contents are left as they are
        if (flush_i) begin
            w_state_d = StFill;
            w_count_d = '0;
            w_ptr_d   = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StFill;
            r_count <= '0;
            r_ptr   <= '0;
        end else begin
            r_state <= w_state_d;
            r_count <= w_count_d;
            r_ptr   <= w_ptr_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_buf <= '{default: '0};
        end else if (w_buf_we) begin
            r_buf[w_buf_waddr] <= w_buf_wdata;
        end
    end

    assign rd_data_o = (rd_addr_i < DepthW) ? r_buf[rd_addr_i] : '0;

endmodule

// File: tb/tb_sort_input_loader.sv
// Randomized bench for sort_input_loader: jobs are driven through fill, sort and drain and
// compared against a transaction-level model of the operand buffer.
module tb_sort_input_loader;

    localparam int D = 9;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] in_data_i = '0;
    logic       in_valid_i = 1'b0;
    logic       in_ready_o;
    logic       flush_i = 1'b0;
    logic       start_o;
    logic       sort_done_i = 1'b0;
    logic [3:0] rd_addr_i = '0;
    logic [7:0] rd_data_o;
    logic       wr_en_i = 1'b0;
    logic [3:0] wr_addr_i = '0;
    logic [7:0] wr_data_i = '0;
    logic [7:0] out_data_o;
    logic       out_valid_o;
    logic       out_ready_i = 1'b0;
    logic [3:0] count_o;
    logic       busy_o;

    int n_total = 0;
    int n_bad = 0;

    logic [7:0] m_buf [D];
    logic [7:0] fill_vals [D];

    always #5 clk = ~clk;

    sort_input_loader #(
        .DATA_W (8),
        .DEPTH  (D),
        .ADDR_W (4)
    ) u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_data_i   (in_data_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .flush_i     (flush_i),
        .start_o     (start_o),
        .sort_done_i (sort_done_i),
        .rd_addr_i   (rd_addr_i),
        .rd_data_o   (rd_data_o),
        .wr_en_i     (wr_en_i),
        .wr_addr_i   (wr_addr_i),
        .wr_data_i   (wr_data_i),
        .out_data_o  (out_data_o),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .count_o     (count_o),
        .busy_o      (busy_o)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0d expected=%0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] m_rd(input logic [3:0] a);
        return (int'(a) < D) ? m_buf[a] : 8'h00;
    endfunction

    // Observable state of an idle loader holding cnt operands
    task automatic chk_fill(input string tag, input int cnt);
        check({tag, "_ready"}, 32'(in_ready_o), 32'(!flush_i));
        check({tag, "_count"}, 32'(count_o), 32'(cnt));
        check({tag, "_start"}, 32'(start_o), 0);
        check({tag, "_busy"}, 32'(busy_o), 0);
        check({tag, "_ovalid"}, 32'(out_valid_o), 0);
        check({tag, "_rd"}, 32'(rd_data_o), 32'(m_rd(rd_addr_i)));
    endtask

    task automatic quiet_inputs();
        in_valid_i  = 1'b0;
        flush_i     = 1'b0;
        sort_done_i = 1'b0;
        wr_en_i     = 1'b0;
        out_ready_i = 1'b0;
    endtask

    // Accepts n operands from fill_vals; a full job also checks the launch and first sort cycle
    task automatic do_fill(input int n, input int gap_mode);
        for (int i = 0; i < n; i++) begin
            int gaps;
            gaps = (gap_mode == 0) ? 0 : (gap_mode == 1) ? 1 : int'($urandom_range(0, 2));
            for (int g = 0; g < gaps; g++) begin
                @(negedge clk);
                in_valid_i = 1'b0;
                in_data_i  = 8'($urandom);
                wr_en_i    = 1'b1;
                wr_addr_i  = (g == 0) ? 4'd0 : 4'($urandom);
                wr_data_i  = 8'($urandom);
                rd_addr_i  = 4'($urandom);
                #1 chk_fill("fill_gap", i);
            end
            @(negedge clk);
            in_valid_i = 1'b1;
            in_data_i  = fill_vals[i];
            wr_en_i    = 1'b0;
            rd_addr_i  = 4'd0;
            #1 chk_fill("fill_acc", i);
            m_buf[i] = fill_vals[i];
        end
        if (n == D) begin
            @(negedge clk);
            in_valid_i  = 1'b1;
            in_data_i   = 8'($urandom);
            sort_done_i = 1'($urandom);
            rd_addr_i   = 4'($urandom);
            #1;
            check("launch_start", 32'(start_o), 1);
            check("launch_busy", 32'(busy_o), 1);
            check("launch_ready", 32'(in_ready_o), 0);
            check("launch_count", 32'(count_o), D);
            check("launch_ovalid", 32'(out_valid_o), 0);
            check("launch_rd", 32'(rd_data_o), 32'(m_rd(rd_addr_i)));
            @(negedge clk);
            in_valid_i  = 1'b0;
            sort_done_i = 1'b0;
            #1;
            check("sort1_start", 32'(start_o), 0);
            check("sort1_busy", 32'(busy_o), 1);
            check("sort1_ovalid", 32'(out_valid_o), 0);
        end
    endtask

    task automatic do_sort(input bit directed);
        int n;
        n = directed ? D : int'($urandom_range(2, 8));
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            if (directed) begin
                wr_en_i   = 1'b1;
                wr_addr_i = 4'(k);
                wr_data_i = 8'(D - k);
            end else begin
                wr_en_i   = 1'($urandom);
                wr_addr_i = 4'($urandom);
                wr_data_i = 8'($urandom);
            end
            rd_addr_i  = 4'($urandom);
            in_valid_i = 1'($urandom);
            #1;
            check("sort_rd", 32'(rd_data_o), 32'(m_rd(rd_addr_i)));
            check("sort_ready", 32'(in_ready_o), 0);
            check("sort_ovalid", 32'(out_valid_o), 0);
            check("sort_start", 32'(start_o), 0);
            check("sort_count", 32'(count_o), D);
            if (wr_en_i && int'(wr_addr_i) < D) m_buf[wr_addr_i] = wr_data_i;
        end
        @(negedge clk);
        wr_en_i     = 1'b0;
        in_valid_i  = 1'b0;
        sort_done_i = 1'b1;
        rd_addr_i   = 4'($urandom);
        #1;
        check("done_rd", 32'(rd_data_o), 32'(m_rd(rd_addr_i)));
        check("done_ovalid", 32'(out_valid_o), 0);
    endtask

    // mode 0: always ready, 1: ready 1,0,1,0..., 2: random; flush lands on beat flush_beat
    task automatic do_drain(input int mode, input int flush_beat);
        int  beat;
        bit  flushed;
        bit  rdy;
        beat = 0;
        flushed = 1'b0;
        for (int c = 0; c < 100 && beat < D && !flushed; c++) begin
            @(negedge clk);
            sort_done_i = 1'b0;
            rdy = (mode == 0) ? 1'b1 : (mode == 1) ? (c % 2 == 0) : 1'($urandom);
            out_ready_i = rdy;
            flush_i     = rdy && (beat == flush_beat);
            in_valid_i  = 1'($urandom);
            wr_en_i     = 1'($urandom);
            wr_addr_i   = 4'($urandom);
            wr_data_i   = 8'($urandom);
            rd_addr_i   = 4'($urandom);
            #1;
            check("drain_valid", 32'(out_valid_o), 1);
            check("drain_data", 32'(out_data_o), 32'(m_buf[beat]));
            check("drain_count", 32'(count_o), 32'(D - beat));
            check("drain_ready", 32'(in_ready_o), 0);
            check("drain_busy", 32'(busy_o), 1);
            check("drain_rd", 32'(rd_data_o), 32'(m_rd(rd_addr_i)));
            if (flush_i) flushed = 1'b1;
            else if (rdy) beat++;
        end
        if (!flushed) check("drain_beats", 32'(beat), D);
        @(negedge clk);
        quiet_inputs();
        rd_addr_i = 4'($urandom);
        #1 chk_fill("after_drain", 0);
    endtask

    initial begin
        for (int i = 0; i < D; i++) m_buf[i] = 8'h00;

        // Reset held for 3 cycles, then the first cycle after release
        repeat (3) begin
            @(negedge clk);
            rd_addr_i = 4'($urandom);
            #1;
            chk_fill("rst", 0);
            check("rst_odata", 32'(out_data_o), 0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1 chk_fill("idle", 0);

        // Gapped fill of the reference operands, directed writeback, toggling backpressure
        fill_vals = '{8'd9, 8'd3, 8'd7, 8'd1, 8'd8, 8'd2, 8'd6, 8'd4, 8'd5};
        do_fill(D, 1);
        do_sort(1'b1);
        do_drain(1, -1);

        // Flush after 4 accepts with a coincident input beat
        for (int i = 0; i < D; i++) fill_vals[i] = 8'($urandom);
        do_fill(4, 0);
        @(negedge clk);
        flush_i    = 1'b1;
        in_valid_i = 1'b1;
        in_data_i  = 8'($urandom);
        rd_addr_i  = 4'd4;
        #1 chk_fill("flush_fill", 4);
        @(negedge clk);
        quiet_inputs();
        rd_addr_i = 4'd4;
        #1 chk_fill("post_flush", 0);

        // Random job with a flush on drain beat 3
        for (int i = 0; i < D; i++) fill_vals[i] = 8'($urandom);
        do_fill(D, 2);
        do_sort(1'b0);
        do_drain(1, 3);

        // Asynchronous reset in the middle of a sort
        for (int i = 0; i < D; i++) fill_vals[i] = 8'($urandom);
        do_fill(D, 0);
        @(negedge clk);
        #2 rst_n = 1'b0;
        for (int i = 0; i < D; i++) m_buf[i] = 8'h00;
        rd_addr_i = 4'($urandom);
        #1;
        chk_fill("async_rst", 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            rd_addr_i = 4'($urandom);
            #1 chk_fill("post_rst", 0);
        end

        // Fully random jobs
        repeat (3) begin
            for (int i = 0; i < D; i++) fill_vals[i] = 8'($urandom);
            do_fill(D, 2);
            do_sort(1'b0);
            do_drain(2, -1);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
